// File: rtl/nco_phase_gen_if.sv
// nco_phase_gen_if -- control/ROM-side signal bundle for the NCO phase generator.
// master: the controller driving strobes and tuning words (e.g. a testbench or
//         the surrounding datapath).
// slave : the phase generator itself.
// Both parameters must match those of the connected nco_phase_gen instance.

interface nco_phase_gen_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
);

  // Sample strobe, phase clear and tuning-word handshake.
  logic                  en_i;
  logic                  sync_i;
  logic [ACC_WIDTH-1:0]  ftw_i;
  logic                  ftw_valid_i;
  logic                  ftw_ready_o;

  // Quarter-wave ROM request and the sign/valid that line up with ROM data.
  logic                  rom_en_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic                  neg_o;
  logic                  valid_o;

  modport master (
    output en_i, sync_i, ftw_i, ftw_valid_i,
    input  ftw_ready_o, rom_en_o, rom_addr_o, neg_o, valid_o
  );

  modport slave (
    input  en_i, sync_i, ftw_i, ftw_valid_i,
    output ftw_ready_o, rom_en_o, rom_addr_o, neg_o, valid_o
  );

endinterface

// File: rtl/nco_phase_gen.sv
// nco_phase_gen -- phase accumulator and quarter-wave ROM address generator.
//
// Each en_i strobe maps the current (pre-increment) phase onto a quarter-wave
// sine ROM address, then advances the phase by the active tuning word.
// The two MSBs of the phase select the quadrant: odd quadrants mirror the
// address, the upper half-cycle sets neg_o so the consumer negates ROM data.
// neg_o/valid_o are delayed one cycle to line up with a registered ROM.
//
// Tuning words are loaded through a one-deep shadow register and take effect
// on the next en_i or sync_i edge, so a frequency change never lands between
// a read and its increment.
//
// Optional feature: define NCO_PHASE_DITHER_EN to add a 32-bit Galois LFSR
// (x^32+x^22+x^2+x+1, seed 0xACE10001) whose low bits are added to the phase
// before mapping. The dither only affects the address, never the stored
// accumulator. Requires ACC_WIDTH-ADDR_WIDTH-2 <= 32.

module nco_phase_gen #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  nco_phase_gen_if.slave  bus
);

  typedef enum logic {
    FTW_IDLE = 1'b0,
    FTW_PEND = 1'b1
  } ftw_state_e;

  // Tuning word handshake state.
  ftw_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  shadow_q, shadow_d;
  logic [ACC_WIDTH-1:0]  ftw_active_q, ftw_active_d;

  // Phase accumulator.
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;

  // Address stage (issued with the ROM read) and sign stage (aligned with data).
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  stage1_q, stage1_d;
  logic                  neg_q, neg_d;
  logic                  valid_q;

  // Phase-to-address mapping: top two bits are the quadrant, next ADDR_WIDTH
  // bits index into the quarter wave.
  logic [ADDR_WIDTH+1:0] map_top;
  logic [1:0]            quad;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr_map;

`ifdef NCO_PHASE_DITHER_EN
  localparam int          LSB_W     = ACC_WIDTH - ADDR_WIDTH - 2;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  // Right-shift Galois toggle mask for x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;

  // LFSR advances once per sample strobe.
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.en_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    end
  end

  // LFSR register; reseeded on reset so the dither sequence is repeatable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Dither is added below the address bits only; carries may ripple into the
  // index/quadrant, which is what spreads the truncation error.
  assign map_top = (ADDR_WIDTH+2)'((acc_q + ACC_WIDTH'(lfsr_q[LSB_W-1:0])) >> LSB_W);
`else
  assign map_top = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH+2];
`endif

  assign quad     = map_top[ADDR_WIDTH+1 -: 2];
  assign idx      = map_top[ADDR_WIDTH-1:0];
  // The ROM stores samples at half-LSB offsets, so the mirror is a plain
  // bitwise inversion with no off-by-one correction.
  assign addr_map = quad[0] ? ~idx : idx;

  // Tuning word FSM: accept into the shadow when idle, commit on the next
  // en_i or sync_i edge.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    ftw_active_d = ftw_active_q;
    case (state_q)
      FTW_IDLE: begin
        if (bus.ftw_valid_i) begin
          shadow_d = bus.ftw_i;
          state_d  = FTW_PEND;
        end
      end
      FTW_PEND: begin
        if (bus.en_i || bus.sync_i) begin
          ftw_active_d = shadow_q;
          state_d      = FTW_IDLE;
        end
      end
      default: begin
        state_d = FTW_IDLE;
      end
    endcase
  end

  // Accumulator next state; the increment uses the word that becomes active
  // on this very edge, so a committed update is felt immediately.
  always_comb begin
    acc_d = acc_q;
    if (bus.sync_i) begin
      acc_d = '0;
    end else if (bus.en_i) begin
      acc_d = acc_q + ftw_active_d;
    end
  end

  // Read-issue and sign pipeline next state.
  always_comb begin
    rom_addr_d = rom_addr_q;
    stage1_d   = stage1_q;
    neg_d      = neg_q;
    if (bus.en_i) begin
      rom_addr_d = addr_map;
      stage1_d   = quad[1];
    end
    if (rom_en_q) begin
      neg_d = stage1_q;
    end
  end

  // Handshake and accumulator registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= FTW_IDLE;
      shadow_q     <= '0;
      ftw_active_q <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      ftw_active_q <= ftw_active_d;
      acc_q        <= acc_d;
    end
  end

  // ROM request and sign/valid alignment registers; reset flushes any
  // in-flight read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      stage1_q   <= 1'b0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rom_en_q   <= bus.en_i;
      rom_addr_q <= rom_addr_d;
      stage1_q   <= stage1_d;
      neg_q      <= neg_d;
      valid_q    <= rom_en_q;
    end
  end

  assign bus.ftw_ready_o = (state_q == FTW_IDLE);
  assign bus.rom_en_o    = rom_en_q;
  assign bus.rom_addr_o  = rom_addr_q;
  assign bus.neg_o       = neg_q;
  assign bus.valid_o     = valid_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen -- self-checking bench for nco_phase_gen.
// A behavioural model tracks phase as a plain integer, maps it to a ROM
// address arithmetically (quarter number and position within the quarter)
// and predicts every output after every clock edge. Directed sequences cover
// reset, a slow sweep, the Nyquist word, FTW back-pressure and phase sync,
// followed by randomized traffic and a mid-stream reset.

module tb_nco_phase_gen;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nco_phase_gen_if #(.ACC_WIDTH(ACC_W), .ADDR_WIDTH(ADDR_W)) bus ();

  nco_phase_gen #(.ACC_WIDTH(ACC_W), .ADDR_WIDTH(ADDR_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit [31:0] m_acc;
  bit [31:0] m_active;
  bit [31:0] m_shadow;
  bit        m_pend;
  bit [31:0] m_lfsr;
  bit        m_rom_en;
  bit [9:0]  m_addr;
  bit        m_inflight_neg;
  bit        m_neg;
  bit        m_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Quarter-wave address from a phase: 4096 steps per cycle at this
  // resolution, 1024 per quarter; odd quarters run backwards.
  function automatic bit [9:0] phase_to_addr(input bit [31:0] ph);
    int unsigned step, quarter, pos;
    step    = ph / (1 << 20);
    quarter = step / 1024;
    pos     = step % 1024;
    return (quarter % 2 == 1) ? 10'(1023 - pos) : 10'(pos);
  endfunction

  function automatic bit [31:0] mapped_phase(input bit [31:0] acc, input bit [31:0] lfsr);
`ifdef NCO_PHASE_DITHER_EN
    return acc + (lfsr % (1 << 20));
`else
    return acc + 0 * lfsr;
`endif
  endfunction

  task automatic model_reset();
    m_acc          = 0;
    m_active       = 0;
    m_shadow       = 0;
    m_pend         = 0;
    m_lfsr         = 32'hACE1_0001;
    m_rom_en       = 0;
    m_addr         = 0;
    m_inflight_neg = 0;
    m_neg          = 0;
    m_valid        = 0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input bit en, input bit sync, input bit fv, input bit [31:0] ftw);
    bit [31:0] ph;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_valid = m_rom_en;
    if (m_rom_en) m_neg = m_inflight_neg;
    m_rom_en = en;
    if (en) begin
      ph             = mapped_phase(m_acc, m_lfsr);
      m_addr         = phase_to_addr(ph);
      m_inflight_neg = (ph >= 32'h8000_0000);
    end
    if (m_pend) begin
      if (en || sync) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
    end else if (fv) begin
      m_shadow = ftw;
      m_pend   = 1;
    end
    if (sync)    m_acc = 0;
    else if (en) m_acc = m_acc + m_active;
    if (en) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ready"},  64'(bus.ftw_ready_o), 64'(!m_pend));
    check({tag, ".rom_en"}, 64'(bus.rom_en_o),    64'(m_rom_en));
    check({tag, ".addr"},   64'(bus.rom_addr_o),  64'(m_addr));
    check({tag, ".neg"},    64'(bus.neg_o),       64'(m_neg));
    check({tag, ".valid"},  64'(bus.valid_o),     64'(m_valid));
  endtask

  // One clock: drive inputs just after an edge, update the model, then
  // sample 1ns after the next rising edge.
  task automatic cycle(input string tag, input bit en, input bit sync, input bit fv,
                       input bit [31:0] ftw);
    bus.en_i        = en;
    bus.sync_i      = sync;
    bus.ftw_valid_i = fv;
    bus.ftw_i       = ftw;
    model_step(en, sync, fv, ftw);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    bus.en_i = 0; bus.sync_i = 0; bus.ftw_valid_i = 0; bus.ftw_i = 0;
    #1;
    compare_all("rst0");

    // Reset held while inputs toggle: outputs stay cleared, ready stays high.
    for (int i = 0; i < 6; i++) begin
      cycle("rst_hold", 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end
    rst_n = 1'b1;

    // Slow sweep: 64 reads per quarter.
    cycle("sweep_load", 0, 0, 1, 32'h0100_0000);
    for (int i = 0; i < 300; i++) begin
      cycle("sweep", 1, 0, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
      if (i == 0)   check("sweep_first_addr", 64'(bus.rom_addr_o), 0);
      if (i == 63)  check("sweep_addr63",     64'(bus.rom_addr_o), 1008);
      if (i == 64)  check("sweep_mirror64",   64'(bus.rom_addr_o), 1023);
      if (i == 65)  check("sweep_mirror65",   64'(bus.rom_addr_o), 1007);
      if (i == 128) check("sweep_neg_before", 64'(bus.neg_o), 0);
      if (i == 129) check("sweep_neg_start",  64'(bus.neg_o), 1);
      if (i == 256) check("sweep_neg_end",    64'(bus.neg_o), 1);
      if (i == 257) check("sweep_neg_clear",  64'(bus.neg_o), 0);
`endif
    end

    // Nyquist word: address stays 0, sign alternates.
    cycle("nyq_sync", 0, 1, 0, 0);
    cycle("nyq_load", 0, 0, 1, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      cycle("nyq", 1, 0, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
      check("nyq_addr", 64'(bus.rom_addr_o), 0);
      if (i >= 1) check("nyq_neg", 64'(bus.neg_o), 64'((i - 1) % 2));
`endif
    end

    // FTW request with no strobe: held pending, later words ignored.
    cycle("bp_sync", 0, 1, 0, 0);
    cycle("bp_load", 0, 0, 1, 32'h0200_0000);
    check("bp_ready_low", 64'(bus.ftw_ready_o), 0);
    for (int i = 0; i < 4; i++) begin
      cycle("bp_hold", 0, 0, 1, $urandom);
    end
    cycle("bp_apply", 1, 0, 0, 0);
    check("bp_ready_back", 64'(bus.ftw_ready_o), 1);
    cycle("bp_next", 1, 0, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
    check("bp_new_step_addr", 64'(bus.rom_addr_o), 32);
`endif

    // Sync mid-stream at phase 0x30000000.
    cycle("sy_sync", 0, 1, 0, 0);
    cycle("sy_load", 0, 0, 1, 32'h1000_0000);
    for (int i = 0; i < 3; i++) cycle("sy_run", 1, 0, 0, 0);
    cycle("sy_clear", 1, 1, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
    check("sy_pre_clear_addr", 64'(bus.rom_addr_o), 768);
`endif
    cycle("sy_after", 1, 0, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
    check("sy_phase0_addr", 64'(bus.rom_addr_o), 0);
`endif

    // Zero tuning word: constant address, valid keeps pulsing.
    cycle("z_sync", 0, 1, 1, 32'h0);
    for (int i = 0; i < 5; i++) cycle("zero_ftw", 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", ($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 3) == 0,
            ($urandom % 2) ? $urandom : ($urandom % (1 << 26)));
    end

    // Asynchronous reset mid-stream with a pending word and reads in flight.
    cycle("mr_load", 1, 0, 1, 32'h0345_6789);
    cycle("mr_run", 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("mid_rst");
    @(posedge clk);
    #1;
    compare_all("mid_rst_hold");
    rst_n = 1'b1;
    cycle("post_rst", 1, 0, 0, 0);
`ifndef NCO_PHASE_DITHER_EN
    check("post_rst_addr", 64'(bus.rom_addr_o), 0);
`endif
    for (int i = 0; i < 4; i++) cycle("post_rst_run", 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
